// File: rtl/door_sequencer.sv
// door_sequencer: elevator door phase sequencer (open, hold, close) that
// drives the shared seconds counter through a tmr_en/tmr_seconds handshake.
// Every phase is preceded by a one-cycle ARM state with tmr_en low, so the
// counter is cleared and tmr_done is low before that phase starts.
// Outputs are registered Moore outputs decoded from the next state, so
// tmr_en and the motor drives never glitch.
module door_sequencer #(
    parameter logic [7:0] OPEN_TIME  = 8'd2,
    parameter logic [7:0] HOLD_TIME  = 8'd5,
    parameter logic [7:0] CLOSE_TIME = 8'd2,
    parameter int         MAX_REOPEN = 3
) (
    input  logic       slowclk,
    input  logic       reset,
    input  logic       open_req,
    input  logic       close_req,
    input  logic       obstruct,
    input  logic       tmr_done,
    output logic       tmr_en,
    output logic [7:0] tmr_seconds,
    output logic       motor_open,
    output logic       motor_close,
    output logic       door_open,
    output logic       door_closed,
    output logic       busy,
    output logic       fault
);

    localparam logic [3:0] MAX_CNT = 4'(MAX_REOPEN);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_ARM_OPEN  = 3'd1,
        ST_OPENING   = 3'd2,
        ST_ARM_HOLD  = 3'd3,
        ST_HOLD      = 3'd4,
        ST_ARM_CLOSE = 3'd5,
        ST_CLOSING   = 3'd6,
        ST_FAULT     = 3'd7
    } state_t;

    state_t     r_state;
    state_t     w_next;
    logic [3:0] r_reopen_cnt;
    logic [3:0] w_reopen_next;

    // Interval loaded for a state: the ARM state already presents the value
    // of the phase it arms, so tmr_seconds is stable before tmr_en rises.
    function automatic logic [7:0] seconds_for(input state_t s);
        case (s)
            ST_ARM_OPEN, ST_OPENING: seconds_for = OPEN_TIME;
            ST_ARM_HOLD, ST_HOLD:    seconds_for = HOLD_TIME;
            ST_ARM_CLOSE, ST_CLOSING: seconds_for = CLOSE_TIME;
            default:                 seconds_for = 8'd0;
        endcase
    endfunction

    // Next-state and reopen-count logic, conditions in priority order.
    always_comb begin
        w_next        = r_state;
        w_reopen_next = r_reopen_cnt;
        case (r_state)
            ST_IDLE: begin
                w_reopen_next = 4'd0;
                if (open_req) w_next = ST_ARM_OPEN;
            end
            ST_ARM_OPEN:  w_next = ST_OPENING;
            ST_OPENING: begin
                if (tmr_done) w_next = ST_ARM_HOLD;
            end
            ST_ARM_HOLD:  w_next = ST_HOLD;
            ST_HOLD: begin
                // A person in the doorway or a fresh open request restarts the hold.
                if (obstruct || open_req)       w_next = ST_ARM_HOLD;
                else if (close_req || tmr_done) w_next = ST_ARM_CLOSE;
            end
            ST_ARM_CLOSE: w_next = ST_CLOSING;
            ST_CLOSING: begin
                // Obstruction outranks both open_req and a coincident tmr_done.
                if (obstruct) begin
                    if (r_reopen_cnt == MAX_CNT) begin
                        w_next = ST_FAULT;
                    end else begin
                        w_next        = ST_ARM_OPEN;
                        w_reopen_next = r_reopen_cnt + 4'd1;
                    end
                end else if (open_req) begin
                    w_next = ST_ARM_OPEN;
                end else if (tmr_done) begin
                    w_next        = ST_IDLE;
                    w_reopen_next = 4'd0;
                end
            end
            ST_FAULT:     w_next = ST_FAULT;
            default:      w_next = ST_IDLE;
        endcase
    end

    // State, reopen count and Moore outputs registered from the next state.
    always_ff @(posedge slowclk or posedge reset) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_reopen_cnt <= 4'd0;
            tmr_en       <= 1'b0;
            tmr_seconds  <= 8'd0;
            motor_open   <= 1'b0;
            motor_close  <= 1'b0;
            door_open    <= 1'b0;
            door_closed  <= 1'b1;
            busy         <= 1'b0;
            fault        <= 1'b0;
        end else begin
            r_state      <= w_next;
            r_reopen_cnt <= w_reopen_next;
            tmr_en       <= (w_next == ST_OPENING) || (w_next == ST_HOLD) ||
                            (w_next == ST_CLOSING);
            tmr_seconds  <= seconds_for(w_next);
            motor_open   <= (w_next == ST_OPENING);
            motor_close  <= (w_next == ST_CLOSING);
            door_open    <= (w_next == ST_ARM_HOLD) || (w_next == ST_HOLD) ||
                            (w_next == ST_ARM_CLOSE) || (w_next == ST_FAULT);
            door_closed  <= (w_next == ST_IDLE);
            busy         <= (w_next != ST_IDLE);
            fault        <= (w_next == ST_FAULT);
        end
    end

endmodule
